adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 161 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter
//
// Purpose: several requesters share one W-bit adder. Each cycle at most one
// valid requester is granted. Its operands are summed (W+1 bits, carry kept)
// into a single output register that the consumer drains.
//
// Arbitration is selected at build time by the macro ADDER_ARB_ROUND_ROBIN_EN:
//   defined   : round-robin. The search starts one past the last granted index.
//   undefined : fixed priority. The lowest index wins and no pointer is kept.
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   reset      in   asynchronous, active-low reset
//   req_valid  in   [NREQ]    per-requester operand valid
//   req_ready  out  [NREQ]    per-requester accept, one-hot or zero
//   req_a      in   [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]  operand B, same packing
//   rsp_valid  out            output register holds a result
//   rsp_ready  in             consumer takes the result this cycle
//   rsp_sum    out  [W+1]     unsigned A+B, carry in MSB
//   rsp_id     out  [clog2(NREQ)] requester that produced rsp_sum
//   dbg_state  out            FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. On the request side, ready is a combinational function of req_valid,
// the FSM state, rsp_ready and the arbiter pointer. A requester holds valid and
// its operands stable until it sees ready. On the response side, rsp_valid
// stays high and rsp_sum/rsp_id stay stable until rsp_ready is seen. A new
// result may be loaded in the same cycle the old one drains.

module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [W:0]                rsp_sum,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      dbg_state
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W:0]      sum_q, sum_d;
    logic [IDW-1:0]  id_q, id_d;

    logic            can_issue;
    logic            grant;
    logic            found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  pos;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    // One extra bit so last_grant + 1 + k (at most 2*NREQ-1) cannot overflow
    // before it is folded back into range.
    logic [IDW:0]    pos_ext;
`endif

    // Arbitration, operand select and next-state logic.
    always_comb begin
        can_issue = (state_q == EMPTY) || rsp_ready;
        found     = 1'b0;
        grant_idx = '0;
        pos       = '0;
        a_sel     = '0;
        b_sel     = '0;
        state_d   = state_q;
        sum_d     = sum_q;
        id_d      = id_q;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        pos_ext      = '0;
`endif

        // Walk the candidates in priority order. The first valid one wins.
        for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            pos_ext = {1'b0, last_grant_q} + (IDW+1)'(k + 1);
            if (pos_ext >= (IDW+1)'(NREQ)) begin
                pos_ext = pos_ext - (IDW+1)'(NREQ);
            end
            pos = pos_ext[IDW-1:0];
`else
            pos = IDW'(k);
`endif
            if (!found && req_valid[pos]) begin
                found     = 1'b1;
                grant_idx = pos;
            end
        end

        // While the output register is blocked or reset is low, nothing is
        // accepted. Gating on reset matters because the FSM already sits
        // in EMPTY during reset.
        grant = found && can_issue && reset;

        // Only the granted requester's operands reach the adder.
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                a_sel = req_a[k*W +: W];
                b_sel = req_b[k*W +: W];
            end
        end

        req_ready = '0;
        if (grant) begin
            req_ready = NREQ'(1) << grant_idx;
        end

        if (grant) begin
            state_d = FULL;
            sum_d   = {1'b0, a_sel} + {1'b0, b_sel};
            id_d    = grant_idx;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            last_grant_d = grant_idx;
`endif
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            id_q    <= '0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            // Pointing at the last index makes requester 0 the first choice.
            last_grant_q <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign dbg_state = (state_q == FULL);

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter.
// The reference keeps the pending result in a queue holding at most one entry.
// The expected grant is found by a plain search over the requesters.
// Directed scenarios pin the reference with literal values. A randomized phase
// follows, with occasional mid-cycle resets.

module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = $clog2(NREQ);
    localparam int E    = IDW + W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W:0]           rsp_sum;
    logic [IDW-1:0]       rsp_id;
    logic                 dbg_state;

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    logic            rv [NREQ];
    logic [W-1:0]    ra [NREQ];
    logic [W-1:0]    rb [NREQ];

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = rv[i];
            req_a[i*W +: W]    = ra[i];
            req_b[i*W +: W]    = rb[i];
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rv[i] = v;
        ra[i] = a;
        rb[i] = b;
        apply();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rb[i] = '0;
        end
        apply();
    endtask

    function automatic logic [W-1:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 2) return {W{1'b1}};
        if (sel == 2) return '0;
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    // Moves to 1 time unit after the next rising edge (drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Ends 3 time units after a rising edge with reset released.
    task automatic reset_dut();
        reset = 1'b0;
        clear_all();
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic [E-1:0] exp_q[$];
    logic [W:0]   hold_sum = '0;
    int           hold_id  = 0;
    int           rr_last  = NREQ - 1;
    int           g_last   = -1;

    function automatic int exp_grant();
        int i;
        if (reset !== 1'b1) return -1;
        if (exp_q.size() > 0 && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            i = (rr_last + 1 + k) % NREQ;
`else
            i = k;
`endif
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model_upd
        int g;
        logic [W:0] s;
        g = -1;
        if (reset === 1'b1) begin
            g = exp_grant();
            if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
            if (g >= 0) begin
                s = W'(0);
                s = (W+1)'(int'(ra[g]) + int'(rb[g]));
                exp_q.push_back({IDW'(g), s});
                hold_sum = s;
                hold_id  = g;
                rr_last  = g;
            end
        end
        g_last = g;
    end

    always @(negedge reset) begin
        exp_q.delete();
        hold_sum = '0;
        hold_id  = 0;
        rr_last  = NREQ - 1;
        g_last   = -1;
    end

    // ---------------- per-cycle compare ----------------
    always begin : compare
        int g;
        @(negedge clk);
        if (cmp_en) begin
            g = exp_grant();
            check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
            check("dbg_state", 32'(dbg_state), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("rsp_sum", 32'(rsp_sum), 32'(exp_q[0][W:0]));
                check("rsp_id",  32'(rsp_id),  32'(exp_q[0][E-1:W+1]));
            end else begin
                check("rsp_sum_hold", 32'(rsp_sum), 32'(hold_sum));
                check("rsp_id_hold",  32'(rsp_id),  32'(hold_id));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_id;
        reset     = 1'b0;
        rsp_ready = 1'b0;
        clear_all();

        // Reset state, with requests present to show req_ready stays low.
        cyc();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'h55, 8'h66);
        at_neg();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        cmp_en = 1'b1;
        cyc();

        // Carry out of the MSB.
        reset_dut();
        set_req(0, 1'b1, 8'hFF, 8'h01);
        rsp_ready = 1'b1;
        at_neg();
        check("carry_req_ready", 32'(req_ready), 32'h1);
        cyc();
        set_req(0, 1'b0, 8'h00, 8'h00);
        at_neg();
        check("carry_rsp_valid", 32'(rsp_valid), 32'd1);
        check("carry_rsp_sum",   32'(rsp_sum),   32'h100);
        check("carry_rsp_id",    32'(rsp_id),    32'd0);
        cyc();

        // All requesting continuously, result drained every cycle.
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, W'(i + 1), W'(2 * i));
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            at_neg();
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            exp_id = k % NREQ;
`else
            exp_id = 0;
`endif
            check("stream_rsp_id",    32'(rsp_id),    32'(exp_id));
            check("stream_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        cyc();
        clear_all();

        // Back-pressure holds the result and blocks new grants.
        reset_dut();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'd10, 8'd20);
        cyc();
        set_req(0, 1'b0, 8'd0, 8'd0);
        set_req(1, 1'b1, 8'd3, 8'd4);
        for (int j = 0; j < 3; j++) begin
            at_neg();
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_sum",   32'(rsp_sum),   32'd30);
            check("bp_rsp_id",    32'(rsp_id),    32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            cyc();
        end
        rsp_ready = 1'b1;
        at_neg();
        check("bp_release_req_ready", 32'(req_ready), 32'h2);
        cyc();
        set_req(1, 1'b0, 8'd0, 8'd0);
        at_neg();
        check("bp_new_sum", 32'(rsp_sum), 32'd7);
        check("bp_new_id",  32'(rsp_id),  32'd1);

        // Single requester 2, then drain to EMPTY.
        cyc();
        set_req(2, 1'b1, 8'd100, 8'd27);
        at_neg();
        check("r2_req_ready", 32'(req_ready), 32'h4);
        check("r2_empty",     32'(rsp_valid), 32'd0);
        cyc();
        set_req(2, 1'b0, 8'd0, 8'd0);
        at_neg();
        check("r2_rsp_sum",   32'(rsp_sum),   32'd127);
        check("r2_rsp_id",    32'(rsp_id),    32'd2);
        check("r2_rsp_valid", 32'(rsp_valid), 32'd1);
        cyc();
        at_neg();
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        check("drain_hold_sum",  32'(rsp_sum),   32'd127);

        // Reset in the middle of a cycle while FULL.
        cyc();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'hFF, 8'hFF);
        cyc();
        set_req(0, 1'b0, 8'h00, 8'h00);
        at_neg();
        check("full_sum_1fe", 32'(rsp_sum), 32'h1FE);
        #2;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, W'(i), W'(i));
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_sum",   32'(rsp_sum),   32'd0);
        check("async_rsp_id",    32'(rsp_id),    32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #3;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        at_neg();
        check("post_rst_id",    32'(rsp_id),    32'd0);
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        cyc();
        clear_all();

        // Randomized traffic with random back-pressure and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                if (g_last == i) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra[i] = rand_op();
                    rb[i] = rand_op();
                end else if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = rand_op();
                    rb[i] = rand_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            apply();
            if ($urandom_range(0, 149) == 0) begin
                #2;
                reset = 1'b0;
                clear_all();
                @(posedge clk);
                #3;
                reset = 1'b1;
            end
        end

        cyc();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
